// File: rtl/supermic_pkg.sv
`default_nettype none
// ============================================================================
//  supermic_pkg
//  Shared defaults, scan FSM encoding and the saturating magnitude helper.
//  Revision: 1.0
// ============================================================================
package supermic_pkg;

  localparam int DELAY_W_DEF = 5;
  localparam int SUM_W_DEF   = 22;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_INTEGRATE = 3'd2,
    ST_COMPARE   = 3'd3,
    ST_LOCK      = 3'd4
  } scan_state_t;

  // |v| in one bit less than v; the most-negative code clamps to the positive max.
  function automatic logic [SUM_W_DEF-2:0] abs_sat(input logic signed [SUM_W_DEF-1:0] v);
    logic [SUM_W_DEF-1:0] neg;
    neg = SUM_W_DEF'(-v);
    if (!v[SUM_W_DEF-1])
      return v[SUM_W_DEF-2:0];
    else if (neg[SUM_W_DEF-1])
      return {(SUM_W_DEF-1){1'b1}};
    else
      return neg[SUM_W_DEF-2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lr_edge_sync.sv
`default_nettype none
// ============================================================================
//  lr_edge_sync
//  Brings lr_clk into the clk domain and emits a one-cycle strobe per frame.
//  Revision: 1.0
// ============================================================================
module lr_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic lr_clk,
  output logic frame_stb
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_sync1 <= lr_clk;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_stb   <= r_sync2 & ~r_prev;
    end
  end

  assign frame_stb = r_stb;

endmodule
`default_nettype wire

// File: rtl/beam_scan_controller.sv
`default_nettype none
// ============================================================================
//  beam_scan_controller
//  Scans every steering direction, integrates |sum_in| and locks onto the best.
//  Revision: 1.0
// ============================================================================
module beam_scan_controller
  import supermic_pkg::*;
#(
  parameter int NUM_DIR       = 32,
  parameter int DELAY_W       = DELAY_W_DEF,
  parameter int SUM_W         = SUM_W_DEF,
  parameter int SETTLE_FRAMES = 4,
  parameter int INT_LOG2      = 6,
  parameter int RESCAN_FRAMES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lr_clk,
  input  logic signed [SUM_W-1:0]       sum_in,
  input  logic                          start,
  input  logic                          auto_rescan,
  input  logic                          manual_en,
  input  logic        [DELAY_W-1:0]     manual_dir,
  output logic        [DELAY_W-1:0]     delay_select,
  output logic        [DELAY_W-1:0]     best_dir,
  output logic        [SUM_W-2+INT_LOG2:0] best_energy,
  output logic                          busy,
  output logic                          done
);

  localparam int c_acc_w     = SUM_W - 1 + INT_LOG2;
  localparam int c_int_n     = 1 << INT_LOG2;
  localparam int c_frame_max = (SETTLE_FRAMES > c_int_n) ? SETTLE_FRAMES : c_int_n;
  localparam int c_cnt_w     = $clog2(c_frame_max + 1);
  localparam int c_rsc_w     = $clog2(RESCAN_FRAMES + 1);

  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_FRAMES - 1);
  localparam logic [c_cnt_w-1:0] c_int_last    = c_cnt_w'(c_int_n - 1);
  localparam logic [c_rsc_w-1:0] c_rsc_last    = c_rsc_w'(RESCAN_FRAMES - 1);
  localparam logic [DELAY_W-1:0] c_last_dir    = DELAY_W'(NUM_DIR - 1);

  logic                 w_frame_stb;
  logic [SUM_W-2:0]     w_mag;

  scan_state_t          r_state,       w_state_nxt;
  logic [DELAY_W-1:0]   r_dir,         w_dir_nxt;
  logic [DELAY_W-1:0]   r_dsel,        w_dsel_nxt;
  logic [DELAY_W-1:0]   r_best_dir,    w_best_dir_nxt;
  logic [c_acc_w-1:0]   r_best_energy, w_best_energy_nxt;
  logic [DELAY_W-1:0]   r_cand_dir,    w_cand_dir_nxt;
  logic [c_acc_w-1:0]   r_cand_energy, w_cand_energy_nxt;
  logic                 r_cand_first,  w_cand_first_nxt;
  logic [c_acc_w-1:0]   r_acc,         w_acc_nxt;
  logic [c_cnt_w-1:0]   r_frame_cnt,   w_frame_cnt_nxt;
  logic [c_rsc_w-1:0]   r_rsc_cnt,     w_rsc_cnt_nxt;
  logic                 r_done,        w_done_nxt;
  logic                 w_begin;
  logic                 w_take;
  logic [DELAY_W-1:0]   w_win_dir;
  logic [c_acc_w-1:0]   w_win_energy;

  lr_edge_sync u_lr_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .lr_clk    (lr_clk),
    .frame_stb (w_frame_stb)
  );

  assign w_mag = abs_sat(sum_in);

  // Direction 0 is always accepted via the first flag; later ties keep the lower index.
  assign w_take       = r_cand_first | (r_acc > r_cand_energy);
  assign w_win_dir    = w_take ? r_dir : r_cand_dir;
  assign w_win_energy = w_take ? r_acc : r_cand_energy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_dir         <= '0;
      r_dsel        <= '0;
      r_best_dir    <= '0;
      r_best_energy <= '0;
      r_cand_dir    <= '0;
      r_cand_energy <= '0;
      r_cand_first  <= 1'b0;
      r_acc         <= '0;
      r_frame_cnt   <= '0;
      r_rsc_cnt     <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dir         <= w_dir_nxt;
      r_dsel        <= w_dsel_nxt;
      r_best_dir    <= w_best_dir_nxt;
      r_best_energy <= w_best_energy_nxt;
      r_cand_dir    <= w_cand_dir_nxt;
      r_cand_energy <= w_cand_energy_nxt;
      r_cand_first  <= w_cand_first_nxt;
      r_acc         <= w_acc_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_rsc_cnt     <= w_rsc_cnt_nxt;
      r_done        <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_dir_nxt         = r_dir;
    w_dsel_nxt        = r_dsel;
    w_best_dir_nxt    = r_best_dir;
    w_best_energy_nxt = r_best_energy;
    w_cand_dir_nxt    = r_cand_dir;
    w_cand_energy_nxt = r_cand_energy;
    w_cand_first_nxt  = r_cand_first;
    w_acc_nxt         = r_acc;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_rsc_cnt_nxt     = r_rsc_cnt;
    w_done_nxt        = 1'b0;
    w_begin           = 1'b0;

    if (manual_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_begin = start;
        end

        ST_SETTLE: begin
          if (w_frame_stb) begin
            if (r_frame_cnt >= c_settle_last) begin
              w_state_nxt     = ST_INTEGRATE;
              w_frame_cnt_nxt = '0;
              w_acc_nxt       = '0;
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + c_cnt_w'(1);
            end
          end
        end

        ST_INTEGRATE: begin
          if (w_frame_stb) begin
            w_acc_nxt = r_acc + c_acc_w'(w_mag);
            if (r_frame_cnt == c_int_last) begin
              w_state_nxt     = ST_COMPARE;
              w_frame_cnt_nxt = '0;
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + c_cnt_w'(1);
            end
          end
        end

        ST_COMPARE: begin
          w_cand_dir_nxt    = w_win_dir;
          w_cand_energy_nxt = w_win_energy;
          w_cand_first_nxt  = 1'b0;
          if (r_dir != c_last_dir) begin
            w_state_nxt     = ST_SETTLE;
            w_dir_nxt       = r_dir + DELAY_W'(1);
            w_dsel_nxt      = r_dsel + DELAY_W'(1);
            // A strobe landing here belongs to the next direction's settle window.
            w_frame_cnt_nxt = w_frame_stb ? c_cnt_w'(1) : '0;
          end else begin
            w_state_nxt       = ST_LOCK;
            w_best_dir_nxt    = w_win_dir;
            w_best_energy_nxt = w_win_energy;
            w_dsel_nxt        = w_win_dir;
            w_done_nxt        = 1'b1;
            w_rsc_cnt_nxt     = '0;
          end
        end

        ST_LOCK: begin
          if (start) begin
            w_begin = 1'b1;
          end else if (auto_rescan) begin
            if (w_frame_stb) begin
              if (r_rsc_cnt >= c_rsc_last)
                w_begin = 1'b1;
              else
                w_rsc_cnt_nxt = r_rsc_cnt + c_rsc_w'(1);
            end
          end else begin
            w_rsc_cnt_nxt = '0;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    if (w_begin) begin
      w_state_nxt       = ST_SETTLE;
      w_dir_nxt         = '0;
      w_dsel_nxt        = '0;
      w_cand_dir_nxt    = '0;
      w_cand_energy_nxt = '0;
      w_cand_first_nxt  = 1'b1;
      w_frame_cnt_nxt   = '0;
      w_rsc_cnt_nxt     = '0;
    end
  end

  assign delay_select = manual_en ? manual_dir : r_dsel;
  assign best_dir     = r_best_dir;
  assign best_energy  = r_best_energy;
  assign done         = r_done;
  assign busy         = (r_state == ST_SETTLE) || (r_state == ST_INTEGRATE) ||
                        (r_state == ST_COMPARE);

endmodule
`default_nettype wire

// File: doc/beam_scan_controller.md
Name: beam_scan_controller

Overview:
Sequences delay_select for the delay/adder beamformer. Steps through every steering direction, lets the delay/CIC pipeline settle, then integrates |sum_out| over a fixed number of PCM frames. Locks delay_select to the highest-energy direction. Sits beside the delay module: it drives delay_select and observes the 22-bit adder sum.

Parameters:
NUM_DIR, 32, number of directions scanned, 0..NUM_DIR-1 (≤ 2^DELAY_W)
DELAY_W, 5, width of delay_select
SUM_W, 22, width of signed beam sum
SETTLE_FRAMES, 4, frames discarded after each delay_select change
INT_LOG2, 6, log2 of frames integrated per direction
RESCAN_FRAMES, 1024, frames spent in LOCK before auto re-scan

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
lr_clk  in  1  frame clock; one rising edge = one PCM frame
sum_in  in  SUM_W  signed beam sum from adder
start  in  1  one-cycle pulse, begins a scan
auto_rescan  in  1  1 = re-scan automatically from LOCK
manual_en  in  1  override; forces delay_select = manual_dir
manual_dir  in  DELAY_W  override direction
delay_select  out  DELAY_W  drive to delay module
best_dir  out  DELAY_W  winning direction of last completed scan
best_energy  out  SUM_W-1+INT_LOG2  energy of best_dir
busy  out  1  high in SETTLE/INTEGRATE/COMPARE
done  out  1  one-cycle pulse at scan completion

Behaviour:
- Reset (rst=0, async): state IDLE; delay_select=0, best_dir=0, best_energy=0, busy=0, done=0; all counters and accumulator cleared; synchroniser flops cleared.
- Frame strobe: lr_clk goes through a 2-FF synchroniser, then a rising-edge detect → frame_stb. frame_stb is one clk cycle wide, 3 cycles after the lr_clk edge. sum_in is sampled in the frame_stb cycle.
- Magnitude: abs(sum_in) is SUM_W-1 bits. The most-negative value saturates to 2^(SUM_W-1)-1.
- Accumulator is SUM_W-1+INT_LOG2 bits and cannot overflow.
- States:
  IDLE: delay_select holds. start → SETTLE with dir=0, delay_select=0, cand_best cleared (energy 0, dir 0).
  SETTLE: count frame_stb. After SETTLE_FRAMES strobes → INTEGRATE with acc=0. The strobe that ends SETTLE is not integrated.
  INTEGRATE: acc += abs on each frame_stb. After 2^INT_LOG2 strobes → COMPARE.
  COMPARE (1 clk): if acc > cand_energy (strict), cand_best ← (dir, acc). Ties keep the lower index. Direction 0 is always taken, since acc ≥ 0 and the candidate starts at 0 with a "first" flag set.
    - If dir < NUM_DIR-1: dir++, delay_select++, → SETTLE.
    - Else: best_dir/best_energy ← cand_best; delay_select ← cand dir; done=1 for one cycle; → LOCK.
  LOCK: delay_select holds at best_dir. If auto_rescan=1, count frame_stb; at RESCAN_FRAMES → SETTLE as if start. If auto_rescan=0, the counter holds at 0. start in LOCK → new scan.
- start while busy: ignored.
- manual_en=1, any state: delay_select = manual_dir (combinational mux on the registered value). The FSM goes to IDLE next cycle; an in-progress scan is aborted; best_dir/best_energy are unchanged; no done pulse. While manual_en=1, start is ignored.
- manual_en falling: delay_select returns to its registered value (last best_dir, or the current dir if the scan was aborted) and the FSM stays in IDLE.
- busy: 1 exactly in SETTLE, INTEGRATE and COMPARE.
- Scan duration: NUM_DIR*(SETTLE_FRAMES+2^INT_LOG2) frames, plus NUM_DIR clks for COMPARE.
- frame_stb coinciding with COMPARE: not possible, since a frame is much longer than 1 clk. Required anyway: the strobe counts toward the next SETTLE.
- Reset mid-scan: immediate return to reset values; no done pulse.

Decomposition:
- supermic_pkg: DELAY_W, SUM_W defaults; FSM state enum (IDLE, SETTLE, INTEGRATE, COMPARE, LOCK); abs/saturate function.
- Sub-module lr_edge_sync: 2-FF synchroniser plus rising-edge detect producing frame_stb. It is shared with other lr_clk consumers.

Test Plan:
All tests use NUM_DIR=4, SETTLE_FRAMES=2, INT_LOG2=2, RESCAN_FRAMES=8.
1. Reset → all outputs 0. Pulse start; sum_in=+100 for dir0, -300 for dir1, +50 for dir2, +200 for dir3 → done after 24 frames; best_dir=1; best_energy=1200; delay_select=1.
2. Tie: sum_in=+500 for dir0 and dir2, 0 elsewhere → best_dir=0, best_energy=2000.
3. Saturation: sum_in=-2^21 for dir3 only → best_energy=4*(2^21-1)=8388604, best_dir=3.
4. manual_en=1, manual_dir=7 during dir2 INTEGRATE → delay_select=7 in the same cycle; busy=0 next cycle; no done pulse; best_* unchanged. Drop manual_en → delay_select=2, state IDLE.
5. auto_rescan=1 after test 1 → 8 frames in LOCK then busy=1 and delay_select=0. start pulsed while busy → ignored; the scan completes normally.
6. Assert rst low mid-SETTLE, asynchronously between clk edges → outputs zero immediately; no done pulse. After release, IDLE until start.
